// File: rtl/dt_pkg.sv
// dt_pkg: shared widths, default burst limit and owner encoding for the result-RAM arbiter.
package dt_pkg;
  localparam int RES_AW = 14;
  localparam int RES_DW = 8;
  localparam int MAX_BURST_DEF = 16;
  typedef enum logic [1:0] {NONE, C0, C1} owner_t;
endpackage

// File: rtl/res_arbiter_if.sv
// res_arbiter_if: two client request/response channels plus the result-RAM port.
interface res_arbiter_if;
  import dt_pkg::*;
  logic c0_req, c0_we, c0_gnt, c0_rvalid;
  logic [RES_AW-1:0] c0_addr;
  logic [RES_DW-1:0] c0_wdata, c0_rdata;
  logic c1_req, c1_we, c1_gnt, c1_rvalid;
  logic [RES_AW-1:0] c1_addr;
  logic [RES_DW-1:0] c1_wdata, c1_rdata;
  logic res_rd, res_wr;
  logic [RES_AW-1:0] res_addr;
  logic [RES_DW-1:0] res_do, res_di;
  modport slave (
    input c0_req, c0_we, c0_addr, c0_wdata, c1_req, c1_we, c1_addr, c1_wdata, res_di,
    output c0_gnt, c0_rvalid, c0_rdata, c1_gnt, c1_rvalid, c1_rdata, res_rd, res_wr, res_addr, res_do
  );
  modport master (
    output c0_req, c0_we, c0_addr, c0_wdata, c1_req, c1_we, c1_addr, c1_wdata, res_di,
    input c0_gnt, c0_rvalid, c0_rdata, c1_gnt, c1_rvalid, c1_rdata, res_rd, res_wr, res_addr, res_do
  );
endinterface

// File: rtl/res_arbiter.sv
// res_arbiter: two-client arbiter for the result RAM with burst-limited ownership and round-robin ties.
module res_arbiter
  import dt_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input logic clk,
  input logic reset,
  res_arbiter_if.slave bus
);
  localparam logic [7:0] MB = 8'(MAX_BURST);
  owner_t owner;
  logic [7:0] burst;
  logic last1;
  logic both, pick1, g0, g1;
  always_comb begin
    both = bus.c0_req & bus.c1_req;
    // under contention the owner keeps the RAM until its burst is spent
    pick1 = owner == C0 ? burst >= MB : owner == C1 ? burst < MB : ~last1;
    g0 = reset & (both ? ~pick1 : bus.c0_req);
    g1 = reset & (both ? pick1 : bus.c1_req);
    bus.c0_gnt = g0;
    bus.c1_gnt = g1;
    bus.res_rd = (g0 & ~bus.c0_we) | (g1 & ~bus.c1_we);
    bus.res_wr = (g0 & bus.c0_we) | (g1 & bus.c1_we);
    bus.res_addr = g0 ? bus.c0_addr : g1 ? bus.c1_addr : '0;
    bus.res_do = g0 ? bus.c0_wdata : g1 ? bus.c1_wdata : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner <= NONE;
      burst <= '0;
      last1 <= 1'b1;
      bus.c0_rvalid <= 1'b0;
      bus.c0_rdata <= '0;
      bus.c1_rvalid <= 1'b0;
      bus.c1_rdata <= '0;
    end else begin
      owner <= g0 ? C0 : g1 ? C1 : NONE;
      burst <= !(g0 | g1) ? 8'd0 : owner == (g0 ? C0 : C1) ? (burst >= MB ? MB : burst + 8'd1) : 8'd1;
      if (g0 | g1) last1 <= g1;
      bus.c0_rvalid <= g0 & ~bus.c0_we;
      bus.c1_rvalid <= g1 & ~bus.c1_we;
      if (g0 & ~bus.c0_we) bus.c0_rdata <= bus.res_di;
      if (g1 & ~bus.c1_we) bus.c1_rdata <= bus.res_di;
    end
  end
endmodule

// File: doc/res_arbiter.md
RES_ARBITER -- requirements
Module: res_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16, meaning max consecutive transfers one client may hold under contention (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports cN_req  input  1  client N (N=0,1) access request, held until granted.
REQ-005 SHALL have ports cN_we  input  1  client N: 1=write, 0=read.
REQ-006 SHALL have ports cN_addr  input  14  client N pixel address.
REQ-007 SHALL have ports cN_wdata  input  8  client N write data.
REQ-008 SHALL have ports cN_gnt  output  1  client N transfer accepted this cycle.
REQ-009 SHALL have ports cN_rvalid  output  1  client N read data valid.
REQ-010 SHALL have ports cN_rdata  output  8  client N read data.
REQ-011 SHALL have port res_rd  output  1  result RAM read strobe.
REQ-012 SHALL have port res_wr  output  1  result RAM write strobe.
REQ-013 SHALL have port res_addr  output  14  result RAM address.
REQ-014 SHALL have port res_do  output  8  result RAM write data.
REQ-015 SHALL have port res_di  input  8  result RAM read data (RAM latches it at falling edge of the read cycle).

Function
REQ-016 SHALL make the grant decision combinationally each cycle from cN_req, registered owner (NONE/C0/C1) and registered burst counter; at most one cN_gnt high per cycle.
REQ-017 SHALL count a transfer on any rising edge where cN_req & cN_gnt are both high; a client's request fields are stable while cN_req is high and ungranted.
REQ-018 SHALL grant the owner when the owner requests and either the other client is idle or burst count < MAX_BURST.
REQ-019 SHALL otherwise grant the other requesting client; with owner NONE and both requesting, grant the client not granted last (rr pointer).
REQ-020 SHALL update owner to the granted client on each transfer and to NONE on a cycle with no grant; burst count = 1 on owner change, +1 on repeat, saturating at MAX_BURST.
REQ-021 SHALL drive res_rd = granted & ~we, res_wr = granted & we, res_addr/res_do from the granted client in the same cycle; with no grant res_rd=res_wr=0, res_addr=0, res_do=0.
REQ-022 SHALL register read responses: cN_rvalid high exactly one cycle, the cycle after the read transfer, with cN_rdata = res_di captured at that same rising edge.
REQ-023 SHALL hold cN_rdata between responses; back-to-back reads yield rvalid on consecutive cycles in issue order.
REQ-024 SHALL make a write visible to a read from either client granted in the following cycle (RAM writes at the rising edge ending the grant cycle).
REQ-025 SHALL bound waiting: a continuously requesting client is granted within MAX_BURST cycles.

Reset
REQ-026 SHALL, while reset=0 at a rising edge, set owner=NONE, burst count=0, rr pointer=C1 (client 0 wins first tie), cN_rvalid=0, cN_rdata=0.
REQ-027 SHALL force cN_gnt=0, res_rd=0, res_wr=0 combinationally while reset=0; a read granted in the cycle reset asserts produces no rvalid.

Structure
REQ-028 SHALL take RES_AW=14, RES_DW=8, default MAX_BURST and the owner enum (NONE/C0/C1) from shared package dt_pkg.
REQ-029 SHALL be one flat module; no sub-module.

Verification
REQ-030 Bench SHALL use the team's res_RAM model (falling-edge read, rising-edge write) and check:
- c0 alone writes 0x05 to addr 0x0010, then reads it -> c0_gnt each request cycle, c0_rvalid one cycle after read grant, c0_rdata=0x05, c1 outputs idle.
- c0, c1 both read from first post-reset cycle -> c0 granted first, then alternation per REQ-018/019, each rvalid routed to correct client.
- MAX_BURST=4, c0 streams 10 reads, c1 requests at cycle 2 -> c0 gets 4 transfers, c1 granted on cycle 5, c1 waits at most 4 cycles.
- c1 writes 0x7F to 0x3FFF, c0 reads 0x3FFF next cycle -> c0_rdata=0x7F.
- reset=0 asserted during c0 read grant -> no rvalid, all strobes 0, owner=NONE; after release c0/c1 tie goes to c0.
- No requests for 20 cycles -> res_rd=res_wr=0, res_addr=0, no rvalid.
